// File: rtl/botao_posicao.sv
// Two-button up/down position controller with synchroniser, debounce,
// saturate-or-wrap limits, optional hold-to-repeat and simultaneous-press lockout.
module botao_posicao #(
    parameter int WIDTH        = 4,
    parameter int POS_MAX      = 9,
    parameter int POS_INIT     = 0,
    parameter int DEBOUNCE     = 4,
    parameter int WRAP         = 0,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SinalBotao1,
    input  logic             SinalBotao2,
    output logic [WIDTH-1:0] posicaofinal,
    output logic             no_minimo,
    output logic             no_maximo,
    output logic             moveu
);

    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [DBW-1:0]   DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [RCW-1:0]   RD_LAST = RCW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RCW-1:0]   RR_LAST = RCW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
    localparam logic [WIDTH-1:0] P_MAX   = WIDTH'(POS_MAX);
    localparam logic [WIDTH-1:0] P_INIT  = WIDTH'(POS_INIT);
    localparam bit               RPT_ON  = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {OCIOSO, SEGURA, REPETE, BLOQ} state_t;

    // Bit 0 is the increment button, bit 1 the decrement button.
    logic [1:0]     raw, meta, sync, deb, deb_q, rise;
    logic [DBW-1:0] cnt [2];

    state_t         state, state_n;
    logic           held, held_n;
    logic [RCW-1:0] rcnt, rcnt_n;
    logic           step, up;
    logic [WIDTH-1:0] pos_n;

    assign raw  = {SinalBotao2, SinalBotao1};
    assign rise = deb & ~deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb    <= '0;
            deb_q  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCIOSO;
            held  <= 1'b0;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            held  <= held_n;
            rcnt  <= rcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        held_n  = held;
        rcnt_n  = rcnt + 1'b1;
        unique case (state)
            OCIOSO: begin
                rcnt_n = '0;
                if (deb[0] && deb[1]) begin
                    state_n = BLOQ;
                end else if (rise[0]) begin
                    state_n = SEGURA;
                    held_n  = 1'b0;
                end else if (rise[1]) begin
                    state_n = SEGURA;
                    held_n  = 1'b1;
                end
            end
            SEGURA: begin
                if (!deb[held]) begin
                    state_n = OCIOSO;
                end else if (deb[~held]) begin
                    state_n = BLOQ;
                end else if (RPT_ON && rcnt == RD_LAST) begin
                    state_n = REPETE;
                    rcnt_n  = '0;
                end
            end
            REPETE: begin
                if (!deb[held]) begin
                    state_n = OCIOSO;
                end else if (deb[~held]) begin
                    state_n = BLOQ;
                end else if (rcnt == RR_LAST) begin
                    rcnt_n = '0;
                end
            end
            BLOQ: begin
                rcnt_n = '0;
                if (deb == 2'b00) state_n = OCIOSO;
            end
            default: state_n = OCIOSO;
        endcase
    end

    always_comb begin
        step = 1'b0;
        up   = 1'b0;
        unique case (state)
            OCIOSO: begin
                if (!(deb[0] && deb[1])) begin
                    if (rise[0]) begin
                        step = 1'b1;
                        up   = 1'b1;
                    end else if (rise[1]) begin
                        step = 1'b1;
                    end
                end
            end
            SEGURA: begin
                if (RPT_ON && deb[held] && !deb[~held] && rcnt == RD_LAST) begin
                    step = 1'b1;
                    up   = ~held;
                end
            end
            REPETE: begin
                if (deb[held] && !deb[~held] && rcnt == RR_LAST) begin
                    step = 1'b1;
                    up   = ~held;
                end
            end
            default: begin
                step = 1'b0;
                up   = 1'b0;
            end
        endcase
    end

    // Limits are compared against POS_MAX so a non-power-of-two range wraps correctly.
    always_comb begin
        if (up) begin
            if (posicaofinal == P_MAX)
                pos_n = (WRAP != 0) ? '0 : posicaofinal;
            else
                pos_n = posicaofinal + 1'b1;
        end else begin
            if (posicaofinal == '0)
                pos_n = (WRAP != 0) ? P_MAX : posicaofinal;
            else
                pos_n = posicaofinal - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posicaofinal <= P_INIT;
            moveu        <= 1'b0;
        end else if (step) begin
            posicaofinal <= pos_n;
            moveu        <= (pos_n != posicaofinal);
        end else begin
            moveu        <= 1'b0;
        end
    end

    assign no_minimo = (posicaofinal == '0);
    assign no_maximo = (posicaofinal == P_MAX);

endmodule

// File: tb/tb_botao_posicao.sv
// Bench for botao_posicao: saturating, wrapping and auto-repeat instances
// driven with directed press tables and hand-timed latency/repeat sequences.
module tb_botao_posicao;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic b1 = 1'b0, b2 = 1'b0, r1 = 1'b0, r2 = 1'b0;
    logic [3:0] p0, p1, p2;
    logic mn0, mx0, mv0, mn1, mx1, mv1, mn2, mx2, mv2;

    int total = 0;
    int passed = 0;
    int n_mv0 = 0;
    int n_mv1 = 0;

    typedef struct {
        bit rst;
        bit b1;
        bit b2;
        int n;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    botao_posicao dut_sat (
        .clk(clk), .rst_n(rst_n), .SinalBotao1(b1), .SinalBotao2(b2),
        .posicaofinal(p0), .no_minimo(mn0), .no_maximo(mx0), .moveu(mv0)
    );

    botao_posicao #(.WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .SinalBotao1(b1), .SinalBotao2(b2),
        .posicaofinal(p1), .no_minimo(mn1), .no_maximo(mx1), .moveu(mv1)
    );

    botao_posicao #(.REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_rep (
        .clk(clk), .rst_n(rst_n), .SinalBotao1(r1), .SinalBotao2(r2),
        .posicaofinal(p2), .no_minimo(mn2), .no_maximo(mx2), .moveu(mv2)
    );

    always @(negedge clk) begin
        if (mv0) n_mv0++;
        if (mv1) n_mv1++;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (tbl[i].rst) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                tick();
            end
            b1 = tbl[i].b1;
            b2 = tbl[i].b2;
            tick(tbl[i].n);
            check($sformatf("row%0d_pos_sat", i), int'(p0), tbl[i].e0);
            check($sformatf("row%0d_pos_wrap", i), int'(p1), tbl[i].e1);
            check($sformatf("row%0d_min_sat", i), int'(mn0), int'(tbl[i].e0 == 0));
            check($sformatf("row%0d_max_wrap", i), int'(mx1), int'(tbl[i].e1 == 9));
        end
    endtask

    initial begin
        int ex;
        int n_press;

        // Presses 2..12 on the increment button (press 1 is the long hold below).
        for (int i = 2; i <= 12; i++) begin
            ex = (i > 9) ? 9 : i;
            tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 8, ex, i % 10});
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8, ex, i % 10});
        end
        n_press = tbl.size();
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 8, 0, 9});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8, 0, 9});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 8, 0, 9});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8, 0, 9});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 8, 0, 9});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 8, 0, 9});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8, 0, 9});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 8, 1, 0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8, 1, 0});

        // Asynchronous reset, checked before any clock edge.
        tick(2);
        rst_n = 1'b0;
        #2;
        check("rst_pos", int'(p0), 0);
        check("rst_min", int'(mn0), 1);
        check("rst_max", int'(mx0), 0);
        check("rst_moveu", int'(mv0), 0);
        check("rst_pos_rep", int'(p2), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Three-cycle glitch is filtered.
        b1 = 1'b1;
        tick(3);
        b1 = 1'b0;
        tick(10);
        check("glitch_pos", int'(p0), 0);
        check("glitch_moveu_cnt", n_mv0, 0);

        // Latency: raw sampled at edge E, position changes at E+6.
        b1 = 1'b1;
        tick(6);
        check("lat_pos_e5", int'(p0), 0);
        check("lat_moveu_e5", int'(mv0), 0);
        tick();
        check("lat_pos_e6", int'(p0), 1);
        check("lat_moveu_e6", int'(mv0), 1);
        check("lat_pos_wrap_e6", int'(p1), 1);
        tick();
        check("lat_moveu_e7", int'(mv0), 0);
        tick(12);
        b1 = 1'b0;
        tick(10);
        check("hold_pos", int'(p0), 1);
        check("hold_moveu_cnt", n_mv0, 1);

        run_rows(0, n_press);
        check("sat_moveu_cnt", n_mv0, 9);
        check("wrap_moveu_cnt", n_mv1, 12);
        check("sat_max_flag", int'(mx0), 1);

        run_rows(n_press, tbl.size());

        // Auto-repeat: steps at E+6, +16, +19, +22, +25 with raw high for 21 edges.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        r1 = 1'b1;
        ex = 0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 21) r1 = 1'b0;
            if (k == 7 || k == 17 || k == 20 || k == 23 || k == 26) begin
                ex++;
                check($sformatf("rep_moveu_k%0d", k), int'(mv2), 1);
            end
            check($sformatf("rep_pos_k%0d", k), int'(p2), ex);
        end
        tick(10);
        check("rep_final_pos", int'(p2), 5);

        // Reset in the middle of a repeat hold.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        r1 = 1'b1;
        tick(19);
        check("midrep_pos_before", int'(p2), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrep_rst_pos", int'(p2), 0);
        check("midrep_rst_min", int'(mn2), 1);
        check("midrep_rst_moveu", int'(mv2), 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("held_thru_rst_e5", int'(p2), 0);
        tick();
        check("held_thru_rst_e6", int'(p2), 1);
        check("held_thru_rst_moveu", int'(mv2), 1);
        r1 = 1'b0;
        tick(10);
        check("held_thru_rst_final", int'(p2), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
